// File: rtl/ot_init_serializer.sv
// ot_init_serializer
//
// Initiator-side serializer for the 1-bit bus. Takes one parallel read/write
// request at a time, shifts out a 16-bit address (LSB first), waits for the
// selected target's acknowledge, then shifts write data out or collects read
// data in. Finishes with a one-cycle parallel response together with a
// release strobe that frees the downstream decoder's held selection.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write/req_addr/req_wdata   request fields, sampled at accept
//   rsp_valid/rsp_rdata/rsp_err    one-cycle response pulse
//   bus_data_out(_valid)  serial address / write-data bit and its qualifier
//   bus_mode              0 = address phase, 1 = data phase
//   bus_write             direction of the transfer in flight, 0 when idle
//   bus_ack               target acknowledge of the address
//   bus_rdata_in(_valid)  serial read data from the target
//   bus_release           one-cycle end-of-transfer strobe
//
// Every output is a flop; the next-state logic computes the value each output
// must show in the state being entered.
module ot_init_serializer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ACK_TIMEOUT   = 32,
  parameter int RDATA_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [15:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  output logic                  bus_write,
  input  logic                  bus_ack,
  input  logic                  bus_rdata_in,
  input  logic                  bus_rdata_in_valid,
  output logic                  bus_release
);

  // One shared counter covers address bits, ack wait, write bits and read wait.
  localparam int CMAX1 = (ACK_TIMEOUT > RDATA_TIMEOUT) ? ACK_TIMEOUT : RDATA_TIMEOUT;
  localparam int CMAX  = (CMAX1 > 16) ? CMAX1 : 16;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int RBW   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT_ACK, WDATA, RDATA, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RBW-1:0]        rbits_q, rbits_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  bus_data_out_q, bus_data_out_d;
  logic                  bus_data_out_valid_q, bus_data_out_valid_d;
  logic                  bus_mode_q, bus_mode_d;
  logic                  bus_write_q, bus_write_d;
  logic                  bus_release_q, bus_release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      cnt_q                <= '0;
      rbits_q              <= '0;
      addr_q               <= '0;
      wdata_q              <= '0;
      rdata_q              <= '0;
      req_ready_q          <= 1'b1;
      rsp_valid_q          <= 1'b0;
      rsp_rdata_q          <= '0;
      rsp_err_q            <= 1'b0;
      bus_data_out_q       <= 1'b0;
      bus_data_out_valid_q <= 1'b0;
      bus_mode_q           <= 1'b0;
      bus_write_q          <= 1'b0;
      bus_release_q        <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      rbits_q              <= rbits_d;
      addr_q               <= addr_d;
      wdata_q              <= wdata_d;
      rdata_q              <= rdata_d;
      req_ready_q          <= req_ready_d;
      rsp_valid_q          <= rsp_valid_d;
      rsp_rdata_q          <= rsp_rdata_d;
      rsp_err_q            <= rsp_err_d;
      bus_data_out_q       <= bus_data_out_d;
      bus_data_out_valid_q <= bus_data_out_valid_d;
      bus_mode_q           <= bus_mode_d;
      bus_write_q          <= bus_write_d;
      bus_release_q        <= bus_release_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    rbits_d              = rbits_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    rdata_d              = rdata_q;
    req_ready_d          = 1'b0;
    rsp_valid_d          = 1'b0;
    rsp_rdata_d          = '0;
    rsp_err_d            = 1'b0;
    bus_data_out_d       = 1'b0;
    bus_data_out_valid_d = 1'b0;
    bus_mode_d           = 1'b0;
    bus_write_d          = bus_write_q;
    bus_release_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          // Bit 0 is presented in the first ADDR cycle, so the shifter keeps
          // only the remaining bits.
          state_d              = ADDR;
          addr_d               = req_addr >> 1;
          wdata_d              = req_wdata;
          rdata_d              = '0;
          rbits_d              = '0;
          cnt_d                = '0;
          bus_write_d          = req_write;
          bus_data_out_d       = req_addr[0];
          bus_data_out_valid_d = 1'b1;
          req_ready_d          = 1'b0;
        end
      end

      ADDR: begin
        if (cnt_q == CW'(15)) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end else begin
          bus_data_out_d       = addr_q[0];
          bus_data_out_valid_d = 1'b1;
          addr_d               = addr_q >> 1;
          cnt_d                = cnt_q + CW'(1);
        end
      end

      WAIT_ACK: begin
        // Ack is checked before the limit so a last-cycle ack still proceeds.
        if (bus_ack) begin
          cnt_d      = '0;
          bus_mode_d = 1'b1;
          if (bus_write_q) begin
            state_d              = WDATA;
            bus_data_out_d       = wdata_q[0];
            bus_data_out_valid_d = 1'b1;
            wdata_d              = wdata_q >> 1;
          end else begin
            state_d = RDATA;
            rbits_d = '0;
            rdata_d = '0;
          end
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          bus_release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WDATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          bus_release_d = 1'b1;
        end else begin
          bus_data_out_d       = wdata_q[0];
          bus_data_out_valid_d = 1'b1;
          bus_mode_d           = 1'b1;
          wdata_d              = wdata_q >> 1;
          cnt_d                = cnt_q + CW'(1);
        end
      end

      RDATA: begin
        bus_mode_d = 1'b1;
        // Bits enter at the MSB and move down, so bit n ends up at rdata[n].
        if (bus_rdata_in_valid) begin
          rdata_d                 = rdata_q >> 1;
          rdata_d[DATA_WIDTH-1]   = bus_rdata_in;
          rbits_d                 = rbits_q + RBW'(1);
        end
        // Completing on the timeout cycle counts as success.
        if (bus_rdata_in_valid && (rbits_q == RBW'(DATA_WIDTH - 1))) begin
          state_d       = DONE;
          bus_mode_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = rdata_d;
          bus_release_d = 1'b1;
        end else if (cnt_q == CW'(RDATA_TIMEOUT - 1)) begin
          state_d       = DONE;
          bus_mode_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          bus_release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        bus_write_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        bus_write_d = 1'b0;
      end
    endcase
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_err            = rsp_err_q;
  assign bus_data_out       = bus_data_out_q;
  assign bus_data_out_valid = bus_data_out_valid_q;
  assign bus_mode           = bus_mode_q;
  assign bus_write          = bus_write_q;
  assign bus_release        = bus_release_q;

endmodule

// File: tb/tb_ot_init_serializer.sv
// Testbench for ot_init_serializer (DATA_WIDTH=8, ACK_TIMEOUT=32,
// RDATA_TIMEOUT=64). A table of transfers with hand-computed results is
// played through a small bus-target responder, followed by a hand-written
// reset-during-address sequence.
module tb_ot_init_serializer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        bus_write;
  logic        bus_ack;
  logic        bus_rdata_in;
  logic        bus_rdata_in_valid;
  logic        bus_release;

  int checks;
  int failures;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ack_at;       // WAIT_ACK cycle (1-based) to ack on; 0 = never
    logic        ack_in_addr;  // hold ack high through the address phase
    logic [7:0]  rd_bits;      // read data the target returns
    int          n_bits;       // how many read bits the target supplies
    int          gap_start;    // RDATA cycle (1-based) where valid idles
    int          gap_len;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    int          exp_wait;     // cycles spent in WAIT_ACK
    int          exp_rd_cyc;   // cycles spent in RDATA
    int          exp_wd_cnt;   // write bits driven
    int          exp_lat;      // cycles from accept edge to rsp_valid cycle
  } vec_t;

  vec_t vecs[8];

  ot_init_serializer #(
    .DATA_WIDTH(8),
    .ACK_TIMEOUT(32),
    .RDATA_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_data_out(bus_data_out),
    .bus_data_out_valid(bus_data_out_valid),
    .bus_mode(bus_mode),
    .bus_write(bus_write),
    .bus_ack(bus_ack),
    .bus_rdata_in(bus_rdata_in),
    .bus_rdata_in_valid(bus_rdata_in_valid),
    .bus_release(bus_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Outputs packed as {req_ready, rsp_valid, rsp_err, bus_data_out,
  // bus_data_out_valid, bus_mode, bus_write, bus_release}.
  function automatic logic [7:0] ctrlBundle();
    return {req_ready, rsp_valid, rsp_err, bus_data_out,
            bus_data_out_valid, bus_mode, bus_write, bus_release};
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    int          cyc;
    int          addr_cnt;
    int          wd_cnt;
    int          wait_cnt;
    int          rd_cyc;
    int          sent;
    int          lat;
    logic [15:0] addr_cap;
    logic [7:0]  wd_cap;
    logic        got;
    logic        write_seen;
    logic        err_s;
    logic        rel_s;
    logic        mode_s;
    logic [7:0]  rdata_s;
    string       tag;

    tag = $sformatf("v%0d", idx);
    cyc = 0; addr_cnt = 0; wd_cnt = 0; wait_cnt = 0; rd_cyc = 0; sent = 0; lat = 0;
    addr_cap = '0; wd_cap = '0; got = 1'b0; write_seen = 1'b0;
    err_s = 1'b0; rel_s = 1'b0; mode_s = 1'b0; rdata_s = '0;

    @(negedge clk);
    checkOutput({tag, "_idle_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    bus_ack   = v.ack_in_addr;
    @(negedge clk);
    // Scramble request inputs after accept; they must not matter any more.
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;

    while (!got && cyc < 300) begin
      cyc++;
      if (cyc == 1) write_seen = bus_write;
      if (rsp_valid) begin
        got     = 1'b1;
        lat     = cyc;
        err_s   = rsp_err;
        rel_s   = bus_release;
        mode_s  = bus_mode;
        rdata_s = rsp_rdata;
      end else if (bus_data_out_valid && !bus_mode) begin
        addr_cap = {bus_data_out, addr_cap[15:1]};
        addr_cnt++;
      end else if (bus_data_out_valid && bus_mode) begin
        wd_cap = {bus_data_out, wd_cap[7:1]};
        wd_cnt++;
      end else if (!bus_mode && addr_cnt >= 16) begin
        wait_cnt++;
      end else if (bus_mode) begin
        rd_cyc++;
      end

      bus_ack            = 1'b0;
      bus_rdata_in       = 1'b0;
      bus_rdata_in_valid = 1'b0;
      if (!got) begin
        if (bus_data_out_valid && !bus_mode) begin
          bus_ack = v.ack_in_addr;
        end else if (!bus_mode && addr_cnt >= 16) begin
          bus_ack = (v.ack_at != 0) && (wait_cnt == v.ack_at);
        end else if (bus_mode && !bus_data_out_valid) begin
          if (sent < v.n_bits &&
              !(rd_cyc >= v.gap_start && rd_cyc < v.gap_start + v.gap_len)) begin
            bus_rdata_in_valid = 1'b1;
            bus_rdata_in       = v.rd_bits[sent[2:0]];
            sent++;
          end
        end
        @(negedge clk);
      end
    end

    checkOutput({tag, "_rsp_seen"}, got, 1);
    checkOutput({tag, "_bus_write"}, write_seen, v.write);
    checkOutput({tag, "_addr_bits"}, addr_cnt, 16);
    checkOutput({tag, "_addr_value"}, addr_cap, v.addr);
    checkOutput({tag, "_wait_cycles"}, wait_cnt, v.exp_wait);
    checkOutput({tag, "_wdata_bits"}, wd_cnt, v.exp_wd_cnt);
    if (v.exp_wd_cnt == 8) checkOutput({tag, "_wdata_value"}, wd_cap, v.wdata);
    checkOutput({tag, "_rdata_cycles"}, rd_cyc, v.exp_rd_cyc);
    checkOutput({tag, "_rsp_err"}, err_s, v.exp_err);
    checkOutput({tag, "_rsp_rdata"}, rdata_s, v.exp_rdata);
    checkOutput({tag, "_release_with_rsp"}, rel_s, 1);
    checkOutput({tag, "_mode_in_done"}, mode_s, 0);
    checkOutput({tag, "_latency"}, lat, v.exp_lat);

    if (got) begin
      @(negedge clk);
      checkOutput({tag, "_after_done"}, ctrlBundle(), 8'b1000_0000);
    end else begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n              = 1'b0;
    req_valid          = 1'b0;
    req_write          = 1'b0;
    req_addr           = '0;
    req_wdata          = '0;
    bus_ack            = 1'b0;
    bus_rdata_in       = 1'b0;
    bus_rdata_in_valid = 1'b0;

    // write, addr, wdata, ack_at, ack_in_addr, rd_bits, n_bits, gap_start,
    // gap_len, exp_err, exp_rdata, exp_wait, exp_rd_cyc, exp_wd_cnt, exp_lat
    vecs[0] = '{1'b1, 16'h4005, 8'hA5, 3,  1'b0, 8'h00, 0, 0, 0,  1'b0, 8'h00, 3,  0,  8, 28};
    vecs[1] = '{1'b0, 16'h8010, 8'h00, 1,  1'b0, 8'h3C, 8, 5, 1,  1'b0, 8'h3C, 1,  9,  0, 27};
    vecs[2] = '{1'b1, 16'hF000, 8'h5A, 0,  1'b0, 8'h00, 0, 0, 0,  1'b1, 8'h00, 32, 0,  0, 49};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 2,  1'b0, 8'hFF, 5, 0, 0,  1'b1, 8'h00, 2,  64, 0, 83};
    vecs[4] = '{1'b1, 16'hABCD, 8'h3C, 32, 1'b1, 8'h00, 0, 0, 0,  1'b0, 8'h00, 32, 0,  8, 57};
    vecs[5] = '{1'b1, 16'h0001, 8'h80, 1,  1'b0, 8'h00, 0, 0, 0,  1'b0, 8'h00, 1,  0,  8, 26};
    vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 4,  1'b0, 8'hC5, 8, 2, 56, 1'b0, 8'hC5, 4,  64, 0, 85};
    vecs[7] = '{1'b0, 16'h0000, 8'h00, 1,  1'b1, 8'h96, 8, 0, 0,  1'b0, 8'h96, 1,  8,  0, 26};

    #23;
    checkOutput("reset_ctrl", ctrlBundle(), 8'b1000_0000);
    checkOutput("reset_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset asserted in the eighth address cycle abandons the transfer.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h1357;
    req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("mid_addr_active", {bus_data_out_valid, bus_mode, bus_write}, 3'b101);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_addr_reset_ctrl", ctrlBundle(), 8'b1000_0000);
    checkOutput("mid_addr_reset_rdata", rsp_rdata, 0);
    @(negedge clk);
    checkOutput("mid_addr_reset_held", ctrlBundle(), 8'b1000_0000);
    rst_n = 1'b1;
    applyStimulus(vecs[5], 8);
    applyStimulus(vecs[1], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
